instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the 16-bit CPU. Drives the memory read handshake at the current PC and
//  captures the returned word in an instruction register. Presents the word and its decoded
//  fields (opcode/rs/rt/rd/func/imm8/target12) to decode, using a valid/ready handshake.
//  Sits directly upstream of the extend units: imm8 feeds the 8->16 sign/zero/lsb extenders,
//  and pc_out plus target12 feed the jump-target concatenation.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  reset           in   1   synchronous, active-high reset
//  readM           out  1   memory read request; registered
//  address         out  16  memory read address; equals pc while readM=1
//  data            in   16  memory read data; sampled only when readM=1 and inputReady=1
//  inputReady      in   1   memory response strobe
//  instr_valid     out  1   instruction register holds a valid instruction for decode
//  instr_ready     in   1   decode accepts the instruction this cycle
//  instr           out  16  instruction register
//  pc_out          out  16  PC of the instruction held in instr
//  opcode          out  4   instr[15:12]
//  rs              out  2   instr[11:10]
//  rt              out  2   instr[9:8]
//  rd              out  2   instr[7:6]
//  func            out  6   instr[5:0]
//  imm8            out  8   instr[7:0]
//  target12        out  12  instr[11:0]
//  redirect_valid  in   1   sampled only on the accept cycle; selects redirect_pc as next PC
//  redirect_pc     in   16  next PC for a taken branch or jump
//  halt            in   1   sampled only on the accept cycle; stops fetch after this instruction
//  halted          out  1   fetch is stopped
// BEHAVIOUR
//  - Reset (synchronous; overrides every other input in the same cycle):
//    pc=RESET_PC, state=FETCH, readM=0, instr=0, instr_valid=0, halted=0.
//    A reset asserted mid-fetch discards any inputReady seen in that same cycle.
//  - States: FETCH, VALID, HALTED.
//  - FETCH: readM=1 from the first cycle after reset/entry; address=pc.
//    - inputReady=1: instr<=data, pc_out<=pc, go VALID. readM is 0 from the next cycle.
//    - inputReady=0: stay in FETCH with readM held at 1 (unbounded wait).
//  - VALID: instr_valid=1, readM=0. instr and pc_out are stable until accepted.
//    - Accept = instr_valid & instr_ready.
//    - On accept: pc <= redirect_valid ? redirect_pc : pc+1. pc+1 is mod 2^16, so FFFF->0000.
//      Clear instr_valid. Go HALTED if halt=1, else FETCH.
//    - Without accept: hold everything; redirect_valid and halt are ignored.
//  - HALTED: readM=0, instr_valid=0, halted=1. Only reset leaves this state.
//  - inputReady outside FETCH is ignored; data is never captured.
//  - Field outputs are combinational slices of instr; no extension is done here.
//  - Latency: request to valid = 1 cycle after inputReady. Minimum 2 cycles per instruction.
// TESTING
//  1. Reset with RESET_PC=0; mem[0]=16'h6A05; inputReady in the first FETCH cycle ->
//     readM=1, address=0000; next cycle instr_valid=1, opcode=6, rs=2, rt=2, rd=0,
//     func=6'h05, imm8=8'h05, target12=12'hA05, pc_out=0000.
//  2. inputReady held low 3 cycles -> readM=1 and address constant for all 4 FETCH cycles;
//     instr_valid stays 0 until the cycle after inputReady.
//  3. instr_ready low 4 cycles in VALID; redirect_valid toggling meanwhile -> instr and
//     pc_out unchanged, readM=0; accept then gives next address = pc+1.
//  4. Accept with redirect_valid=1, redirect_pc=16'h1234 -> next FETCH address=1234.
//     Accept at pc=FFFF without redirect -> next address=0000.
//  5. Accept with halt=1 -> halted=1, readM stays 0 for 10 cycles despite inputReady pulses;
//     reset then restarts fetch at RESET_PC.
//  6. Reset asserted in a FETCH cycle with inputReady=1, data=16'hBEEF -> instr=0,
//     instr_valid=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 16-bit CPU: reads the word at pc, holds it in the instruction
// register and hands it to decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        readM,
    output logic [15:0] address,
    input  logic [15:0] data,
    input  logic        inputReady,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] pc_out,
    output logic [3:0]  opcode,
    output logic [1:0]  rs,
    output logic [1:0]  rt,
    output logic [1:0]  rd,
    output logic [5:0]  func,
    output logic [7:0]  imm8,
    output logic [11:0] target12,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        capture;
    logic        accept;

    // A response only counts while the request is actually on the bus.
    assign capture = (state == FETCH) && readM && inputReady;
    assign accept  = instr_valid && instr_ready;
    assign address = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pc_out      <= RESET_PC;
            readM       <= 1'b0;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    readM <= 1'b1;
                    if (capture) begin
                        instr       <= data;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        readM       <= 1'b0;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    // Redirect and halt are only meaningful on the accept cycle.
                    if (accept) begin
                        pc          <= redirect_valid ? redirect_pc : pc + 16'd1;
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                            readM  <= 1'b0;
                        end else begin
                            state <= FETCH;
                            readM <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    readM       <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state <= FETCH;
                    readM <= 1'b0;
                end
            endcase
        end
    end

    assign opcode   = instr[15:12];
    assign rs       = instr[11:10];
    assign rt       = instr[9:8];
    assign rd       = instr[7:6];
    assign func     = instr[5:0];
    assign imm8     = instr[7:0];
    assign target12 = instr[11:0];

endmodule
